// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer that shares one UART transmitter among
// NUM_REQ requesters, tracking the Tx busy flag through each frame.
module uart_tx_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int DATA_WIDTH    = 8,
  parameter  int START_TIMEOUT = 16,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  input  logic [NUM_REQ-1:0]            req_par_type,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_par_en,
  output logic                          tx_par_type,
  output logic [ID_W-1:0]               owner_id,
  output logic                          frame_done,
  output logic                          timeout_err,
  output logic                          arb_busy
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timeout_q, timeout_d;

  logic                  win_found;
  logic [ID_W-1:0]       win_idx;

  // Search upward from last_grant+1 with wrap, so the last owner is checked last.
  always_comb begin
    int unsigned cand;
    logic [ID_W-1:0] cand_id;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_id = cand[ID_W-1:0];
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    data_d       = data_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!tx_busy && win_found) begin
          state_d    = S_ISSUE;
          owner_d    = win_idx;
          last_d     = win_idx;
          data_d     = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          par_en_d   = req_par_en[win_idx];
          par_type_d = req_par_type[win_idx];
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          // Compare the incremented value so the error lands START_TIMEOUT cycles after ISSUE.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(START_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      data_q       <= data_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_ISSUE) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  assign tx_data_valid = (state_q == S_ISSUE);
  assign tx_p_data     = data_q;
  assign tx_par_en     = par_en_q;
  assign tx_par_type   = par_type_q;
  assign owner_id      = owner_q;
  assign frame_done    = frame_done_q;
  assign timeout_err   = timeout_q;
  assign arb_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a behavioural Tx model plus a grant
// scoreboard filled as requests are driven and drained on each Data_Valid.
module tb_uart_tx_arbiter;

  localparam int NR        = 4;
  localparam int DW        = 8;
  localparam int TMO       = 16;
  localparam int FRAME_LEN = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_par_en = '0;
  logic [NR-1:0]   req_par_type = '0;
  logic [NR-1:0]   req_ready;
  logic            tx_busy;
  logic            tx_data_valid;
  logic [DW-1:0]   tx_p_data;
  logic            tx_par_en;
  logic            tx_par_type;
  logic [1:0]      owner_id;
  logic            frame_done;
  logic            timeout_err;
  logic            arb_busy;

  logic model_busy = 1'b0;
  logic ext_busy   = 1'b0;
  logic tx_dead    = 1'b0;
  assign tx_busy = model_busy | ext_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .START_TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_type(req_par_type),
    .req_ready(req_ready), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data),
    .tx_par_en(tx_par_en), .tx_par_type(tx_par_type),
    .owner_id(owner_id), .frame_done(frame_done),
    .timeout_err(timeout_err), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          pe;
    logic          pt;
  } exp_t;

  exp_t sb[$];
  exp_t cur = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int frame_cnt = 0;
  int to_cnt = 0;
  int last_issue = 0;
  int prev_issue = 0;
  int ready_cnt[NR] = '{default: 0};
  logic prev_busy = 1'b0;
  logic busy_fell_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = req_data[id*DW +: DW];
    e.pe   = req_par_en[id];
    e.pt   = req_par_type[id];
    sb.push_back(e);
  endtask

  // which: 0 grants, 1 frames, 2 timeouts
  task automatic wait_for(input string tag, input int which, input int target, input int budget);
    bit reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      @(negedge clk);
      #1;
      case (which)
        0: reached = (grant_cnt >= target);
        1: reached = (frame_cnt >= target);
        default: reached = (to_cnt >= target);
      endcase
    end
    check(tag, 64'(reached), 64'd1);
  endtask

  task automatic drive_at_edge();
    @(posedge clk);
    #2;
  endtask

  // Tx model: busy rises on the edge after Data_Valid and stays up FRAME_LEN cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_data_valid && !tx_dead) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (FRAME_LEN) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_data_valid) begin
        grant_cnt++;
        prev_issue = last_issue;
        last_issue = cyc;
        check("grant_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("grant_owner", 64'(owner_id), 64'(cur.id));
          check("grant_data", 64'(tx_p_data), 64'(cur.data));
          check("grant_par_en", 64'(tx_par_en), 64'(cur.pe));
          check("grant_par_type", 64'(tx_par_type), 64'(cur.pt));
          check("grant_ready_onehot", 64'(req_ready), 64'(4'b0001 << cur.id));
        end
      end else if (req_ready !== '0) begin
        check("ready_without_dv", 64'(req_ready), 64'd0);
      end
      for (int i = 0; i < NR; i++) ready_cnt[i] += int'(req_ready[i]);
      if (frame_done) begin
        frame_cnt++;
        check("fd_after_busy_fall", 64'(busy_fell_prev), 64'd1);
        check("fd_owner", 64'(owner_id), 64'(cur.id));
        check("fd_data_held", 64'(tx_p_data), 64'(cur.data));
        check("fd_par_held", 64'({tx_par_en, tx_par_type}), 64'({cur.pe, cur.pt}));
      end
      if (timeout_err) begin
        to_cnt++;
        check("timeout_latency", 64'(cyc - last_issue), 64'(TMO));
      end
    end
    busy_fell_prev = prev_busy && !tx_busy;
    prev_busy      = tx_busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int f;
    int r3;

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_dv", 64'(tx_data_valid), 64'd0);
    check("rst_data", 64'(tx_p_data), 64'd0);
    check("rst_par", 64'({tx_par_en, tx_par_type}), 64'd0);
    check("rst_owner", 64'(owner_id), 64'd0);
    check("rst_pulses", 64'({frame_done, timeout_err, arb_busy}), 64'd0);

    // Single request, latency and hold
    drive_at_edge();
    req_data[7:0] = 8'hA5;
    req_par_en    = 4'b0001;
    req_par_type  = 4'b0000;
    req_valid     = 4'b0001;
    push_exp(0);
    @(posedge clk);
    @(negedge clk);
    check("single_latency_dv", 64'(tx_data_valid), 64'd1);
    check("single_latency_ready", 64'(req_ready), 64'b0001);
    drive_at_edge();
    req_valid = '0;
    wait_for("single_frame_done", 1, 1, 40);
    check("single_owner", 64'(owner_id), 64'd0);

    // Round robin after reset: 0,1,2,3,0
    drive_at_edge();
    rst = 1'b1;
    drive_at_edge();
    rst = 1'b0;
    req_data     = {8'h3C, 8'hC3, 8'h5A, 8'h81};
    req_par_en   = 4'b0110;
    req_par_type = 4'b1010;
    req_valid    = 4'b1111;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    wait_for("rr_grants", 0, grant_cnt + 5, 5 * (FRAME_LEN + 3) + 20);
    drive_at_edge();
    req_valid = '0;
    check("rr_throughput", 64'(last_issue - prev_issue), 64'(FRAME_LEN + 3));
    wait_for("rr_frames", 1, 6, 40);

    // Timeout: Tx never goes busy, next requester granted afterwards
    tx_dead = 1'b1;
    g = grant_cnt;
    drive_at_edge();
    req_valid = 4'b0110;
    push_exp(1); push_exp(2);
    wait_for("to_first_grant", 0, g + 1, 10);
    drive_at_edge();
    req_valid = 4'b0100;
    wait_for("to_pulse", 2, 1, 30);
    check("to_no_frame_done", 64'(frame_cnt), 64'd6);
    drive_at_edge();
    tx_dead = 1'b0;
    wait_for("to_next_grant", 0, g + 2, 5);
    drive_at_edge();
    req_valid = '0;
    wait_for("to_next_frame", 1, 7, 40);

    // Tx already busy from an external source
    g = grant_cnt;
    drive_at_edge();
    ext_busy  = 1'b1;
    req_valid = 4'b0010;
    push_exp(1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("busy_no_grant", 64'(grant_cnt), 64'(g));
    drive_at_edge();
    ext_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_release_dv", 64'(tx_data_valid), 64'd1);
    check("busy_release_ready", 64'(req_ready), 64'b0010);
    drive_at_edge();
    req_valid = '0;
    wait_for("busy_frame", 1, 8, 40);

    // Withdrawn request during another owner's frame
    g  = grant_cnt;
    r3 = ready_cnt[3];
    drive_at_edge();
    req_valid = 4'b0001;
    push_exp(0);
    wait_for("wd_grant", 0, g + 1, 10);
    drive_at_edge();
    req_valid = 4'b1000;
    repeat (3) @(posedge clk);
    #2 req_valid = '0;
    wait_for("wd_frame", 1, 9, 40);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("wd_never_granted", 64'(ready_cnt[3]), 64'(r3));
    check("wd_grant_count", 64'(grant_cnt), 64'(g + 1));

    // Reset during WAIT_DONE
    g = grant_cnt;
    drive_at_edge();
    req_valid = 4'b0100;
    push_exp(2);
    wait_for("rst_mid_grant", 0, g + 1, 10);
    drive_at_edge();
    req_valid = '0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    drive_at_edge();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(arb_busy), 64'd0);
    check("rst_mid_owner", 64'(owner_id), 64'd0);
    check("rst_mid_data", 64'(tx_p_data), 64'd0);
    check("rst_mid_par", 64'({tx_par_en, tx_par_type}), 64'd0);
    f = frame_cnt;
    drive_at_edge();
    req_valid = 4'b1111;
    push_exp(0);
    wait_for("rst_mid_next_grant", 0, g + 2, 30);
    drive_at_edge();
    req_valid = '0;
    wait_for("rst_mid_frame", 1, f + 1, 40);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_mid_frame_count", 64'(frame_cnt), 64'(f + 1));
    check("timeout_count", 64'(to_cnt), 64'd1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
